// File: rtl/mode_pkg.sv
// Shared mode codes, initiator state encoding and feedback helpers for the
// mode-selection initiator.
package mode_pkg;

    localparam logic [1:0] MODE_NONE   = 2'b00;
    localparam logic [1:0] MODE_LEARN  = 2'b01;
    localparam logic [1:0] MODE_ASSESS = 2'b10;
    localparam logic [1:0] MODE_GAME   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        DONE,
        ERROR
    } init_state_t;

    // Feedback order is {l_m, a_m, g_m}.
    function automatic logic [2:0] expected_fb(input logic [1:0] mode);
        logic [2:0] fb;
        case (mode)
            MODE_LEARN:  fb = 3'b100;
            MODE_ASSESS: fb = 3'b010;
            MODE_GAME:   fb = 3'b001;
            default:     fb = 3'b000;
        endcase
        return fb;
    endfunction

    // True when the responder claims more than one mode at once.
    function automatic logic multi_hot(input logic [2:0] fb);
        return (fb[2] & fb[1]) | (fb[2] & fb[0]) | (fb[1] & fb[0]);
    endfunction

    // Candidate cycling skips MODE_NONE.
    function automatic logic [1:0] next_cand(input logic [1:0] mode);
        return (mode == MODE_GAME) ? MODE_LEARN : mode + 2'b01;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Counts consecutive high samples of a raw button and emits exactly one
// registered press pulse per hold once DEBOUNCE_CYCLES samples are seen.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_FIRE = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // NOTE: state registers use <= so every flop samples pre-edge values;
    // blocking assignments here would make cnt and press order-dependent.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            // Fires only on the step into CNT_MAX; saturation blocks repeats.
            press <= raw && (cnt == CNT_FIRE);
            if (!raw) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mode_request_initiator.sv
// Button-driven initiator: debounces the trainer buttons, issues a one-cycle
// load request to the mode-selection responder and checks its feedback.
module mode_request_initiator
    import mode_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACK_TIMEOUT     = 8,
    parameter int MAX_RETRY       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_confirm,
    input  logic       btn_clear,
    input  logic       l_m,
    input  logic       a_m,
    input  logic       g_m,
    output logic       mode_selector,
    output logic       pass_load,
    output logic [1:0] mode_ip,
    output logic [1:0] cand_mode,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    logic press_next;
    logic press_confirm;
    logic press_clear;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_next),
        .press (press_next)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_confirm (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_confirm),
        .press (press_confirm)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_clear),
        .press (press_clear)
    );

    init_state_t   state, state_d;
    logic [1:0]    req, req_d;
    logic [1:0]    cand, cand_d;
    logic [TW-1:0] timer, timer_d;
    logic [RW-1:0] retry, retry_d;
    logic [2:0]    fb;

    assign fb        = {l_m, a_m, g_m};
    assign cand_mode = cand;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            req   <= MODE_NONE;
            cand  <= MODE_LEARN;
            timer <= '0;
            retry <= '0;
        end else begin
            state <= state_d;
            req   <= req_d;
            cand  <= cand_d;
            timer <= timer_d;
            retry <= retry_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state;
        req_d         = req;
        cand_d        = cand;
        timer_d       = timer;
        retry_d       = retry;
        mode_selector = 1'b0;
        pass_load     = 1'b0;
        mode_ip       = MODE_NONE;
        busy          = 1'b0;
        done          = 1'b0;
        err           = 1'b0;

        case (state)
            IDLE: begin
                // clear > confirm > next; lower-priority pulses are dropped.
                if (press_clear) begin
                    req_d   = MODE_NONE;
                    retry_d = '0;
                    state_d = ISSUE;
                end else if (press_confirm) begin
                    req_d   = cand;
                    retry_d = '0;
                    state_d = ISSUE;
                end else if (press_next) begin
                    cand_d = next_cand(cand);
                end
            end

            ISSUE: begin
                mode_selector = 1'b1;
                pass_load     = 1'b1;
                mode_ip       = req;
                busy          = 1'b1;
                timer_d       = '0;
                state_d       = WAIT_ACK;
            end

            WAIT_ACK: begin
                mode_selector = 1'b1;
                mode_ip       = req;
                busy          = 1'b1;
                // A contradictory responder outranks both match and timeout.
                if (multi_hot(fb)) begin
                    state_d = ERROR;
                end else if (fb == expected_fb(req)) begin
                    state_d = DONE;
                end else if (timer == TIMER_LAST) begin
                    if (retry < RETRY_MAX) begin
                        retry_d = retry + RW'(1);
                        state_d = ISSUE;
                    end else begin
                        state_d = ERROR;
                    end
                end else begin
                    timer_d = timer + TW'(1);
                end
            end

            DONE: begin
                done    = 1'b1;
                retry_d = '0;
                state_d = IDLE;
            end

            ERROR: begin
                err = 1'b1;
                if (press_clear) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mode_request_initiator.sv
// Directed self-checking bench for mode_request_initiator with a small
// registered responder model answering on each pass_load.
module tb_mode_request_initiator;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_next, btn_confirm, btn_clear;
    logic       l_m, a_m, g_m;
    logic       mode_selector, pass_load, busy, done, err;
    logic [1:0] mode_ip, cand_mode;

    int checks   = 0;
    int failures = 0;
    int resp_kind = 0;  // 0 = correct answer, 1 = silent, 2 = illegal 110

    mode_request_initiator #(
        .DEBOUNCE_CYCLES(DEB),
        .ACK_TIMEOUT    (8),
        .MAX_RETRY      (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_next      (btn_next),
        .btn_confirm   (btn_confirm),
        .btn_clear     (btn_clear),
        .l_m           (l_m),
        .a_m           (a_m),
        .g_m           (g_m),
        .mode_selector (mode_selector),
        .pass_load     (pass_load),
        .mode_ip       (mode_ip),
        .cand_mode     (cand_mode),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    // Responder model: registers its answer on the edge where pass_load is high.
    always @(posedge clk) begin
        if (rst) begin
            {l_m, a_m, g_m} <= 3'b000;
        end else if (pass_load) begin
            case (resp_kind)
                0: begin
                    case (mode_ip)
                        2'b01:   {l_m, a_m, g_m} <= 3'b100;
                        2'b10:   {l_m, a_m, g_m} <= 3'b010;
                        2'b11:   {l_m, a_m, g_m} <= 3'b001;
                        default: {l_m, a_m, g_m} <= 3'b000;
                    endcase
                end
                1:       {l_m, a_m, g_m} <= 3'b000;
                default: {l_m, a_m, g_m} <= 3'b110;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // 0 = next, 1 = confirm, 2 = clear. Returns right after the FSM consumed the pulse.
    task automatic press(input int which);
        case (which)
            0:       btn_next    = 1'b1;
            1:       btn_confirm = 1'b1;
            default: btn_clear   = 1'b1;
        endcase
        repeat (DEB) tick();
        btn_next    = 1'b0;
        btn_confirm = 1'b0;
        btn_clear   = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p_idx[4];
        int n_pl;
        int first_err;
        int extra_pl;

        rst = 1'b1;
        btn_next = 1'b0;
        btn_confirm = 1'b0;
        btn_clear = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_selector", mode_selector, 0);
        check("rst_pass_load", pass_load, 0);
        check("rst_mode_ip", mode_ip, 0);
        check("rst_busy_done_err", {busy, done, err}, 0);
        check("rst_cand", cand_mode, 2'b01);

        // Short hold is rejected, long hold advances exactly once
        btn_next = 1'b1;
        repeat (3) tick();
        btn_next = 1'b0;
        tick();
        check("short_hold_cand", cand_mode, 2'b01);
        btn_next = 1'b1;
        repeat (10) tick();
        check("long_hold_cand", cand_mode, 2'b10);
        btn_next = 1'b0;
        repeat (2) tick();
        check("long_hold_once", cand_mode, 2'b10);

        // Wrap 11 -> 01, then two presses to reach game
        press(0);
        check("cand_11", cand_mode, 2'b11);
        press(0);
        check("cand_wrap", cand_mode, 2'b01);
        press(0);
        press(0);
        check("cand_game", cand_mode, 2'b11);

        // Confirm game with latency check and a cooperative responder
        resp_kind = 0;
        btn_confirm = 1'b1;
        repeat (DEB) tick();
        check("lat_no_load_yet", pass_load, 0);
        btn_confirm = 1'b0;
        tick();
        check("game_pass_load", pass_load, 1);
        check("game_mode_ip", mode_ip, 2'b11);
        check("game_issue_busy", {mode_selector, busy}, 2'b11);
        tick();
        check("game_wait_no_load", {pass_load, done, mode_selector}, 3'b001);
        tick();
        check("game_done", {done, mode_selector}, 2'b10);
        tick();
        check("game_idle", {done, mode_selector, busy}, 0);

        // Silent responder: three issues 9 cycles apart, then ERROR
        press(0);
        check("silent_cand", cand_mode, 2'b01);
        resp_kind = 1;
        press(1);
        check("silent_first_load", pass_load, 1);
        n_pl = 1;
        p_idx[0] = 0;
        first_err = -1;
        for (int i = 1; i <= 35; i++) begin
            tick();
            if (pass_load && n_pl < 4) begin
                p_idx[n_pl] = i;
                n_pl++;
            end
            if (err && first_err < 0) first_err = i;
        end
        check("silent_load_count", 8'(n_pl), 3);
        check("silent_retry1_at", 8'(p_idx[1]), 9);
        check("silent_retry2_at", 8'(p_idx[2]), 18);
        check("silent_err_at", 8'(first_err), 27);
        check("silent_err_held", {err, busy, mode_selector}, 3'b100);

        // Clear leaves ERROR without issuing
        press(2);
        check("clear_err_low", err, 0);
        extra_pl = 0;
        for (int i = 0; i < 12; i++) begin
            if (pass_load || busy) extra_pl++;
            tick();
        end
        check("clear_no_request", 8'(extra_pl), 0);

        // Illegal two-hot feedback
        resp_kind = 2;
        press(1);
        check("illegal_issue", pass_load, 1);
        tick();
        check("illegal_wait", {err, busy}, 2'b01);
        tick();
        check("illegal_error", {err, busy, mode_selector}, 3'b100);
        press(2);
        check("illegal_cleared", err, 0);

        // Clear and confirm together: clear wins, request 00
        resp_kind = 0;
        btn_clear = 1'b1;
        btn_confirm = 1'b1;
        repeat (DEB) tick();
        btn_clear = 1'b0;
        btn_confirm = 1'b0;
        tick();
        check("both_pass_load", pass_load, 1);
        check("both_mode_ip", mode_ip, 2'b00);
        tick();
        check("both_first_wait", {busy, done}, 2'b10);
        tick();
        check("both_done", done, 1);
        check("both_cand_kept", cand_mode, 2'b01);
        tick();

        // Reset mid WAIT_ACK
        press(0);
        check("pre_rst_cand", cand_mode, 2'b10);
        resp_kind = 1;
        press(1);
        check("pre_rst_mode_ip", mode_ip, 2'b10);
        tick();
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_outputs", {mode_selector, pass_load, mode_ip, busy, done, err}, 0);
        check("mid_rst_cand", cand_mode, 2'b01);
        rst = 1'b0;
        tick();
        resp_kind = 0;
        press(1);
        check("post_rst_load", {pass_load, mode_ip}, 3'b101);
        tick();
        tick();
        check("post_rst_done", done, 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
